// File: rtl/stage_wb.sv
// stage_wb: writeback stage, retires memory-stage instructions as single registered register-file write pulses
//   clk, reset (async, active-low)
//   m_valid/m_w_en/m_is_load/m_rd/m_funct3/m_addr_lo/m_pro : instruction from the memory stage
//   mem_rdata_valid/mem_rdata : load data return strobe and aligned doubleword
//   wb_busy : load outstanding, upstream holds
//   w_en/w_rd/w_in : registered register-file write port
//   retire_count : completed instruction counter (wraps)
module stage_wb #(
    parameter int ADDR_WIDTH = 64,
    parameter int REG_NUM = 32,
    localparam int RW = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_valid,
    input  logic                  m_w_en,
    input  logic                  m_is_load,
    input  logic [RW-1:0]         m_rd,
    input  logic [2:0]            m_funct3,
    input  logic [2:0]            m_addr_lo,
    input  logic [ADDR_WIDTH-1:0] m_pro,
    input  logic                  mem_rdata_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rdata,
    output logic                  wb_busy,
    output logic                  w_en,
    output logic [RW-1:0]         w_rd,
    output logic [ADDR_WIDTH-1:0] w_in,
    output logic [63:0]           retire_count
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;
    logic [RW-1:0] s_rd;
    logic s_w_en;
    logic [2:0] s_funct3, s_off;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_w;
    logic [ADDR_WIDTH-1:0] ext;
    logic take_alu, take_load, finish_load;

    assign take_alu    = state == IDLE && m_valid && !m_is_load;
    assign take_load   = state == IDLE && m_valid && m_is_load;
    assign finish_load = state == WAIT && mem_rdata_valid;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = take_load ? WAIT : finish_load ? IDLE : state;

    always_comb
        wb_busy = state == WAIT;

    // Offset bits below the access size drop out of the lane index, so misaligned offsets round down.
    always_comb begin
        lane_b = mem_rdata[{s_off, 3'b000} +: 8];
        lane_h = mem_rdata[{s_off[2:1], 4'b0000} +: 16];
        lane_w = mem_rdata[{s_off[2], 5'b00000} +: 32];
        case (s_funct3)
            3'd0:    ext = {{(ADDR_WIDTH-8){lane_b[7]}}, lane_b};
            3'd1:    ext = {{(ADDR_WIDTH-16){lane_h[15]}}, lane_h};
            3'd2:    ext = {{(ADDR_WIDTH-32){lane_w[31]}}, lane_w};
            3'd3:    ext = mem_rdata;
            3'd4:    ext = {{(ADDR_WIDTH-8){1'b0}}, lane_b};
            3'd5:    ext = {{(ADDR_WIDTH-16){1'b0}}, lane_h};
            3'd6:    ext = {{(ADDR_WIDTH-32){1'b0}}, lane_w};
            default: ext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            w_en         <= 1'b0;
            w_rd         <= '0;
            w_in         <= '0;
            retire_count <= '0;
            s_rd         <= '0;
            s_w_en       <= 1'b0;
            s_funct3     <= '0;
            s_off        <= '0;
        end else begin
            w_en <= 1'b0;
            if (take_alu) begin
                w_en         <= m_w_en && m_rd != '0;
                w_rd         <= m_rd;
                w_in         <= m_pro;
                retire_count <= retire_count + 64'd1;
            end
            if (take_load) begin
                s_rd     <= m_rd;
                s_w_en   <= m_w_en;
                s_funct3 <= m_funct3;
                s_off    <= m_addr_lo;
            end
            if (finish_load) begin
                w_en         <= s_w_en && s_rd != '0;
                w_rd         <= s_rd;
                w_in         <= ext;
                retire_count <= retire_count + 64'd1;
            end
        end
endmodule

// File: tb/tb_stage_wb.sv
// tb_stage_wb: randomized and directed self-checking bench for stage_wb against a behavioural load model
module tb_stage_wb;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_w_en = 1'b0;
    logic        m_is_load = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [2:0]  m_funct3 = '0;
    logic [2:0]  m_addr_lo = '0;
    logic [63:0] m_pro = '0;
    logic        mem_rdata_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        wb_busy;
    logic        w_en;
    logic [4:0]  w_rd;
    logic [63:0] w_in;
    logic [63:0] retire_count;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_cnt = '0;
    logic [63:0] exp_in = '0;
    logic [4:0]  exp_rd = '0;

    stage_wb dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_w_en(m_w_en), .m_is_load(m_is_load),
        .m_rd(m_rd), .m_funct3(m_funct3), .m_addr_lo(m_addr_lo), .m_pro(m_pro),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata), .wb_busy(wb_busy),
        .w_en(w_en), .w_rd(w_rd), .w_in(w_in), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_ext(input logic [2:0] f3, input logic [2:0] off, input logic [63:0] d);
        int sz;
        logic [63:0] v, m;
        if (f3 == 3'd7) return 64'd0;
        if (f3 == 3'd3) return d;
        sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        v = d >> (8 * ((int'(off) / sz) * sz));
        m = (64'd1 << (8 * sz)) - 64'd1;
        v = v & m;
        if (f3 < 3'd4 && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    task automatic check_idle(input string nm, input logic strobe);
        m_valid = 1'b0;
        mem_rdata_valid = strobe;
        mem_rdata = {$urandom, $urandom};
        @(posedge clk); #1;
        mem_rdata_valid = 1'b0;
        checks++;
        if (w_en !== 1'b0 || w_rd !== exp_rd || w_in !== exp_in || retire_count !== exp_cnt || wb_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=%b, required w_en=0 w_rd=%0d w_in=%h cnt=%0d busy=0",
                     nm, w_en, w_rd, w_in, retire_count, wb_busy, exp_rd, exp_in, exp_cnt);
        end
    endtask

    task automatic issue_nonload(input string nm, input logic [4:0] rd, input logic wen, input logic [63:0] pro);
        m_valid = 1'b1; m_is_load = 1'b0; m_rd = rd; m_w_en = wen; m_pro = pro;
        m_funct3 = 3'($urandom); m_addr_lo = 3'($urandom);
        @(posedge clk); #1;
        m_valid = 1'b0;
        exp_cnt = exp_cnt + 64'd1; exp_rd = rd; exp_in = pro;
        checks++;
        if (w_en !== (wen && rd != 0) || w_rd !== exp_rd || w_in !== exp_in || retire_count !== exp_cnt || wb_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=%b, required w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=0",
                     nm, w_en, w_rd, w_in, retire_count, wb_busy, wen && rd != 0, exp_rd, exp_in, exp_cnt);
        end
    endtask

    task automatic issue_load(input string nm, input logic [4:0] rd, input logic wen, input logic [2:0] f3,
                              input logic [2:0] off, input logic [63:0] data, input int delay,
                              input logic same_strobe, input logic [63:0] want);
        m_valid = 1'b1; m_is_load = 1'b1; m_rd = rd; m_w_en = wen; m_funct3 = f3; m_addr_lo = off;
        m_pro = {$urandom, $urandom};
        mem_rdata_valid = same_strobe; mem_rdata = data;
        @(posedge clk); #1;
        mem_rdata_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            checks++;
            if (wb_busy !== 1'b1 || w_en !== 1'b0 || retire_count !== exp_cnt) begin
                failures++;
                $display("FAIL %s_wait%0d: busy=%b w_en=%b cnt=%0d, required busy=1 w_en=0 cnt=%0d",
                         nm, i, wb_busy, w_en, retire_count, exp_cnt);
            end
            m_valid = 1'($urandom); m_is_load = 1'($urandom); m_rd = 5'($urandom); m_w_en = 1'b1;
            m_funct3 = 3'($urandom); m_addr_lo = 3'($urandom); m_pro = {$urandom, $urandom};
            mem_rdata_valid = i == delay - 1;
            mem_rdata = (i == delay - 1) ? data : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        m_valid = 1'b0; mem_rdata_valid = 1'b0;
        exp_cnt = exp_cnt + 64'd1; exp_rd = rd; exp_in = want;
        checks++;
        if (w_en !== (wen && rd != 0) || w_rd !== exp_rd || w_in !== exp_in || retire_count !== exp_cnt || wb_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s: w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=%b, required w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=0",
                     nm, w_en, w_rd, w_in, retire_count, wb_busy, wen && rd != 0, exp_rd, exp_in, exp_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_cnt = '0; exp_rd = '0; exp_in = '0;
        checks++;
        if (w_en !== 1'b0 || w_rd !== 5'd0 || w_in !== 64'd0 || retire_count !== 64'd0 || wb_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=%b, required all 0", w_en, w_rd, w_in, retire_count, wb_busy);
        end
    endtask

    task automatic test_nonload();
        issue_nonload("nonload_rd5", 5'd5, 1'b1, 64'h1234);
        check_idle("nonload_rd5_after", 1'b0);
        issue_nonload("nonload_x0", 5'd0, 1'b1, 64'hDEAD_BEEF);
        check_idle("nonload_x0_after", 1'b0);
        issue_nonload("nonload_nowen", 5'd9, 1'b0, 64'h55);
        check_idle("nonload_nowen_after", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) issue_nonload($sformatf("b2b%0d", i), 5'(i + 1), 1'b1, {$urandom, $urandom});
        check_idle("b2b_after", 1'b0);
    endtask

    task automatic test_loads();
        issue_load("lb_off3", 5'd7, 1'b1, 3'd0, 3'd3, 64'h0000_0000_8000_0000, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        check_idle("lb_after", 1'b0);
        issue_load("lbu_off3", 5'd7, 1'b1, 3'd4, 3'd3, 64'h0000_0000_8000_0000, 1, 1'b0, 64'h80);
        issue_load("lw_off4", 5'd8, 1'b1, 3'd2, 3'd4, 64'h8000_0001_0000_0000, 2, 1'b0, 64'hFFFF_FFFF_8000_0001);
        issue_load("lwu_off4", 5'd8, 1'b1, 3'd6, 3'd4, 64'h8000_0001_0000_0000, 1, 1'b0, 64'h0000_0000_8000_0001);
        issue_load("ld", 5'd10, 1'b1, 3'd3, 3'd5, 64'h8000_0001_0000_0000, 1, 1'b0, 64'h8000_0001_0000_0000);
        issue_load("f3_7", 5'd11, 1'b1, 3'd7, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 64'd0);
        issue_load("lh_off7", 5'd12, 1'b1, 3'd1, 3'd7, 64'h9234_0000_0000_0000, 1, 1'b0, 64'hFFFF_FFFF_FFFF_9234);
        issue_load("load_x0", 5'd0, 1'b1, 3'd3, 3'd0, 64'h1111_2222_3333_4444, 2, 1'b0, 64'h1111_2222_3333_4444);
        check_idle("load_x0_after", 1'b0);
    endtask

    task automatic test_stray_strobe();
        check_idle("idle_strobe", 1'b1);
        issue_load("same_cycle_strobe", 5'd13, 1'b1, 3'd3, 3'd0, 64'hCAFE_F00D_0BAD_BEEF, 2, 1'b1, 64'hCAFE_F00D_0BAD_BEEF);
    endtask

    task automatic test_reset_mid_wait();
        m_valid = 1'b1; m_is_load = 1'b1; m_rd = 5'd9; m_w_en = 1'b1; m_funct3 = 3'd3; m_addr_lo = 3'd0;
        @(posedge clk); #1;
        m_valid = 1'b0;
        checks++;
        if (wb_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_busy: busy=%b, required 1", wb_busy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        exp_cnt = '0; exp_rd = '0; exp_in = '0;
        checks++;
        if (w_en !== 1'b0 || w_rd !== 5'd0 || w_in !== 64'd0 || retire_count !== 64'd0 || wb_busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_async: w_en=%b w_rd=%0d w_in=%h cnt=%0d busy=%b, required all 0", w_en, w_rd, w_in, retire_count, wb_busy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        check_idle("rst_wait_late_strobe", 1'b1);
    endtask

    task automatic test_wrap();
        force dut.retire_count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.retire_count;
        exp_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        issue_nonload("wrap", 5'd3, 1'b1, 64'h77);
    endtask

    task automatic test_random();
        logic [63:0] d;
        logic [2:0] f3, off;
        logic [4:0] rd;
        for (int n = 0; n < 40; n++) begin
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                issue_nonload($sformatf("rnd_alu%0d", n), rd, 1'($urandom), {$urandom, $urandom});
            end else begin
                d = {$urandom, $urandom}; f3 = 3'($urandom); off = 3'($urandom);
                issue_load($sformatf("rnd_ld%0d_f%0d_o%0d", n, f3, off), rd, 1'($urandom), f3, off, d,
                           $urandom_range(1, 4), 1'($urandom), model_ext(f3, off, d));
            end
            if ($urandom_range(0, 2) == 0) check_idle($sformatf("rnd_idle%0d", n), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_back_to_back();
        test_loads();
        test_stray_strobe();
        test_reset_mid_wait();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
